// File: rtl/bf_ram_arbiter.sv
// Two-requester arbiter (core, host) for one shared registered array RAM.
// Optional BF_ARB_ROUND_ROBIN_EN: round-robin grant instead of core priority.
module bf_ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  logic   win;

`ifdef BF_ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  // rr_ptr names the requester favoured on the next tie
  always_comb begin
    win = host_req;
    if (core_req && host_req) win = rr_ptr;
  end
`else
  always_comb begin
    win = !core_req;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      core_ack   <= 1'b0;
      host_ack   <= 1'b0;
      core_rdata <= '0;
      host_rdata <= '0;
      owner      <= 1'b0;
`ifdef BF_ARB_ROUND_ROBIN_EN
      rr_ptr     <= 1'b0;
`endif
    end else begin
      core_ack <= 1'b0;
      host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req || host_req) begin
            owner     <= win;
            ram_addr  <= win ? host_addr : core_addr;
            ram_wdata <= win ? host_wdata : core_wdata;
            ram_we    <= win ? host_we : core_we;
`ifdef BF_ARB_ROUND_ROBIN_EN
            rr_ptr    <= !win;
`endif
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          ram_we <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          if (owner) begin
            host_rdata <= ram_rdata;
            host_ack   <= 1'b1;
          end else begin
            core_rdata <= ram_rdata;
            core_ack   <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          ram_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
